byte_frame_tx: RTL and testbench
================================

# byte_frame_tx

Transmit-side framer for the 8-bit byte stream consumed by the design's top-level byte-oriented state machine. It accepts a payload length and a stream of payload bytes, and emits a framed byte stream: start-of-frame byte, length byte, payload, and an optional checksum. The output is registered and uses a valid/ready handshake. It sits between a payload source and the byte input of the receiving state machine.

## Interface
- `SOF`, default 8'hA5: start-of-frame byte value.
- `MAX_LEN`, default 16: largest accepted payload length, in the range 1..255.
- `CLK` input, 1: the single clock; all state changes on the rising edge.
- `RST_X` input, 1: asynchronous, active-low reset.
- `START` input, 1: request a frame. Sampled only in IDLE.
- `LEN` input, 8: payload byte count. Latched when START is accepted.
- `IN` input, 8: payload byte.
- `IN_VALID` input, 1: IN holds a valid byte.
- `IN_READY` output, 1: the block takes IN on this cycle if IN_VALID is high.
- `OUT` output, 8: framed byte.
- `OUT_VALID` output, 1: OUT is valid.
- `OUT_READY` input, 1: the downstream consumer takes OUT.
- `BUSY` output, 1: high whenever the state is not IDLE.
- `DONE` output, 1: one-cycle pulse when the last frame byte is accepted downstream.
- `ERR` output, 1: one-cycle pulse when START is rejected because LEN > MAX_LEN.

## Operation
- States: IDLE, HDR_SOF, HDR_LEN, PAYLOAD, CSUM. CSUM exists only when CHECKSUM_EN is defined.
- **IDLE**
  - START=1 and LEN ≤ MAX_LEN: latch LEN into `len_q`, clear `cnt` and `sum`, go to HDR_SOF.
  - START=1 and LEN > MAX_LEN: pulse ERR and stay in IDLE.
- **HDR_SOF:** load OUT=SOF with OUT_VALID=1. On acceptance, go to HDR_LEN.
- **HDR_LEN:** load OUT=len_q and set sum=len_q. On acceptance:
  - len_q=0: go to CSUM (or finish, without the checksum).
  - otherwise: go to PAYLOAD.
- **PAYLOAD**
  - IN_READY = (state==PAYLOAD) && (!OUT_VALID || OUT_READY).
  - On an IN transfer: OUT←IN, OUT_VALID←1, sum←sum+IN (mod 256), cnt←cnt+1.
  - When the transfer with cnt==len_q−1 is accepted downstream: go to CSUM (or finish).
- **CSUM:** OUT = (−sum) mod 256, so that LEN + payload + CSUM ≡ 0 (mod 256). On acceptance, finish.
- **Finish:** pulse DONE on the cycle of the last downstream acceptance, and return to IDLE.
- "Acceptance" means OUT_VALID && OUT_READY at a rising clock edge.
- A byte on OUT is never dropped or duplicated. If OUT_READY is low, OUT and OUT_VALID stay stable.
- START outside IDLE is ignored. ERR is not raised for it.
- IN_VALID outside PAYLOAD is ignored, and IN_READY=0 there.
- `cnt` is 8 bits wide and never wraps, because len_q ≤ MAX_LEN ≤ 255.

## Timing
- Reset values: OUT=0, OUT_VALID=0, IN_READY=0, BUSY=0, DONE=0, ERR=0, state=IDLE.
- Asserting RST_X mid-frame abandons the frame immediately. No DONE is pulsed, and the partial frame is not resumed.
- Latency from START acceptance to first OUT_VALID (SOF) is 1 cycle.
- With OUT_READY held high and IN_VALID held high, the block sustains 1 byte per cycle.
- A full frame of N payload bytes takes 2+N(+1) cycles from the first OUT_VALID to DONE.
- The next START is accepted in the cycle after DONE (IDLE for at least one cycle).
- ERR is asserted in the cycle after the rejected START.
- IN_READY is a combinational function of state, OUT_VALID and OUT_READY. There is no combinational path from IN_VALID.

## Configuration
- `BYTE_FRAME_TX_CHECKSUM_EN`
  - **Defined:** the CSUM state exists and every frame ends with the checksum byte. A frame is N+3 bytes.
  - **Undefined:** the CSUM state and the `sum` register are removed, and the frame ends after the last payload byte (or after LEN when N=0). A frame is N+2 bytes.

## Structure
- Shared package `byte_frame_pkg`:
  - State enum `frame_state_t`.
  - Default `SOF` constant.
  - Checksum function `csum_negate(sum)`, shared with the receive side.
- One sub-module, `byte_out_reg`: the output holding register with valid/ready. It provides load-enable and can-load (!valid || ready).
- The FSM and counters live in `byte_frame_tx`.

## Test plan
- **Basic frame (checksum enabled):** LEN=3, payload 01,02,03, OUT_READY=1 → OUT = A5,03,01,02,03,F7. DONE pulses on the F7 acceptance, and the frame takes 6 cycles.
- **Zero length:** LEN=0 → OUT = A5,00,00, then DONE. IN_READY stays 0 throughout.
- **Over-length:** LEN=17 with MAX_LEN=16 → ERR pulses 1 cycle later, BUSY stays 0, OUT_VALID stays 0.
- **Backpressure:** LEN=2 (AA,55), OUT_READY low for 3 cycles while OUT=AA → OUT holds AA, IN_READY=0, and the 55 byte is not taken. The result is A5,02,AA,55,FF.
- **START while busy:** START pulsed during PAYLOAD with LEN=5 → ignored, and the current frame completes unchanged.
- **Reset mid-frame:** RST_X low during PAYLOAD → all outputs 0 immediately. A new START with LEN=1 (7E) gives A5,01,7E,81.

Source files
------------

// File: rtl/byte_frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_frame_pkg: frame state encoding, default SOF value and checksum helper.
// Rev 1.0 -- initial release. Option: BYTE_FRAME_TX_CHECKSUM_EN.
// ----------------------------------------------------------------------------
package byte_frame_pkg;

    localparam logic [7:0] c_SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_SOF = 3'd1,
        ST_HDR_LEN = 3'd2,
        ST_PAYLOAD = 3'd3
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
        ,
        ST_CSUM    = 3'd4
`endif
    } frame_state_t;

    // Two's complement, so LEN + payload + checksum sums to zero mod 256.
    function automatic logic [7:0] csum_negate(input logic [7:0] sum);
        return 8'(~sum + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_out_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_out_reg: single-entry output holding register with valid/ready.
// Rev 1.0 -- initial release.
// ----------------------------------------------------------------------------
module byte_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_can_load
);

    logic [7:0] r_data;
    logic       r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_can_load = !r_valid || i_ready;

endmodule
`default_nettype wire

// File: rtl/byte_frame_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// byte_frame_tx: emits SOF, LEN, payload [, checksum] with valid/ready output.
// Rev 1.0 -- initial release. Option: BYTE_FRAME_TX_CHECKSUM_EN adds checksum.
// ----------------------------------------------------------------------------
module byte_frame_tx
    import byte_frame_pkg::*;
#(
    parameter logic [7:0] SOF     = c_SOF_DEFAULT,
    parameter int         MAX_LEN = 16
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       START,
    input  logic [7:0] LEN,
    input  logic [7:0] IN,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] OUT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

    frame_state_t r_state;
    logic [7:0]   r_len;
    logic [7:0]   r_cnt;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
    logic [7:0]   r_sum;
`endif
    logic         r_done;
    logic         r_err;

    logic         w_load;
    logic [7:0]   w_load_data;
    logic         w_can_load;
    logic         w_accept;
    logic         w_in_ready;
    logic         w_in_xfer;
    logic         w_start_ok;
    logic         w_last_out;

    assign w_accept   = OUT_VALID && OUT_READY;
    // r_cnt counts bytes taken from IN; once it reaches r_len the payload is complete.
    assign w_in_ready = (r_state == ST_PAYLOAD) && w_can_load && (r_cnt != r_len);
    assign w_in_xfer  = w_in_ready && IN_VALID;
    assign w_start_ok = (r_state == ST_IDLE) && START && (LEN <= c_MAX_LEN);
    assign w_last_out = w_accept && (r_cnt == r_len);

    always_comb begin
        w_load      = 1'b0;
        w_load_data = SOF;
        case (r_state)
            ST_IDLE: w_load = w_start_ok;
            ST_HDR_SOF: begin
                w_load      = w_accept;
                w_load_data = r_len;
            end
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
            ST_HDR_LEN: begin
                w_load      = w_accept;
                w_load_data = csum_negate(r_sum);
            end
`endif
            ST_PAYLOAD: begin
                w_load      = w_in_xfer;
                w_load_data = IN;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                if (w_last_out) begin
                    w_load      = 1'b1;
                    w_load_data = csum_negate(r_sum);
                end
`endif
            end
            default: ;
        endcase
    end

    // A non-empty frame enters PAYLOAD while LEN is still in the output
    // register, so the first payload byte can follow LEN without a bubble.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= ST_IDLE;
            r_len   <= 8'd0;
            r_cnt   <= 8'd0;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
            r_sum   <= 8'd0;
`endif
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_len   <= LEN;
                        r_cnt   <= 8'd0;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                        r_sum   <= 8'd0;
`endif
                        r_state <= ST_HDR_SOF;
                    end else if (START) begin
                        r_err <= 1'b1;
                    end
                end
                ST_HDR_SOF: begin
                    if (w_accept) begin
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                        r_sum <= r_len;
`endif
                        if (r_len == 8'd0) begin
                            r_state <= ST_HDR_LEN;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_HDR_LEN: begin
                    if (w_accept) begin
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                        r_state <= ST_CSUM;
`else
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (w_in_xfer) begin
                        r_cnt <= r_cnt + 8'd1;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                        r_sum <= r_sum + IN;
`endif
                    end else if (w_last_out) begin
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                        r_state <= ST_CSUM;
`else
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end
                end
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    byte_out_reg u_out_reg (
        .clk        (CLK),
        .rst_n      (RST_X),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_ready    (OUT_READY),
        .o_data     (OUT),
        .o_valid    (OUT_VALID),
        .o_can_load (w_can_load)
    );

    assign IN_READY = w_in_ready;
    assign BUSY     = (r_state != ST_IDLE);
    assign DONE     = r_done;
    assign ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_byte_frame_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_byte_frame_tx: randomized and directed frames against a queue-based frame model.
// Rev 1.0 -- initial release.
// ----------------------------------------------------------------------------
module tb_byte_frame_tx;

    localparam logic [7:0] c_sof     = 8'hA5;
    localparam int         c_max_len = 16;
`ifdef BYTE_FRAME_TX_CHECKSUM_EN
    localparam int         c_csum_bytes = 1;
`else
    localparam int         c_csum_bytes = 0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       CLK       = 1'b0;
    logic       RST_X     = 1'b1;
    logic       START     = 1'b0;
    logic [7:0] LEN       = 8'd0;
    logic [7:0] IN        = 8'd0;
    logic       IN_VALID  = 1'b0;
    logic       OUT_READY = 1'b0;
    logic       IN_READY;
    logic [7:0] OUT;
    logic       OUT_VALID;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    byte_frame_tx #(
        .SOF     (c_sof),
        .MAX_LEN (c_max_len)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .START     (START),
        .LEN       (LEN),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame = SOF, LEN, payload, then optionally the byte making LEN+payload+csum == 0 mod 256.
    function automatic void model_frame(input int len, input byte_q_t pay, output byte_q_t frm);
        int s;
        frm = {};
        frm.push_back(c_sof);
        frm.push_back(8'(len));
        s = len;
        foreach (pay[i]) begin
            frm.push_back(pay[i]);
            s += int'(pay[i]);
        end
        if (c_csum_bytes != 0) frm.push_back(8'((256 - (s % 256)) % 256));
    endfunction

    task automatic run_frame(input int len, input byte_q_t pay, input int rdy_pct,
                             input int vld_pct, input bit poke, input bit chk_span);
        byte_q_t    exp_q;
        byte_q_t    got_q;
        int         pidx      = 0;
        int         cyc       = 0;
        int         first     = -1;
        bit         done_seen = 1'b0;
        bit         last_acc  = 1'b0;
        bit         hold      = 1'b0;
        logic [7:0] hold_val  = 8'd0;
        model_frame(len, pay, exp_q);
        START = 1'b1;
        LEN   = 8'(len);
        @(posedge CLK); #1;
        START = 1'b0;
        LEN   = 8'($urandom);
        while (!done_seen && cyc < 2000) begin
            OUT_READY = ($urandom_range(99) < 32'(rdy_pct));
            if (pidx < pay.size()) begin
                IN_VALID = ($urandom_range(99) < 32'(vld_pct));
                IN       = pay[pidx];
            end else begin
                IN_VALID = 1'($urandom_range(1));
                IN       = 8'($urandom);
            end
            START = poke && (cyc == 3 || cyc == 4);
            LEN   = (cyc == 3) ? 8'd5 : 8'd200;
            #1;
            if (OUT_VALID && first < 0) first = cyc;
            if (hold) begin
                check_b("hold_valid", OUT_VALID, 1'b1);
                check_w("hold_data", 32'(OUT), 32'(hold_val));
            end
            check_b("busy_in_frame", BUSY, 1'b1);
            if (pidx >= pay.size()) check_b("in_ready_no_payload", IN_READY, 1'b0);
            if (IN_READY && IN_VALID) pidx++;
            if (OUT_VALID && OUT_READY) got_q.push_back(OUT);
            last_acc = OUT_VALID && OUT_READY && (got_q.size() >= exp_q.size());
            hold     = OUT_VALID && !OUT_READY;
            hold_val = OUT;
            @(posedge CLK); #1;
            cyc++;
            START = 1'b0;
            check_b("err_quiet", ERR, 1'b0);
            if (last_acc) begin
                check_b("done_pulse", DONE, 1'b1);
                done_seen = 1'b1;
            end else begin
                check_b("done_early", DONE, 1'b0);
            end
        end
        check_b("done_timeout", done_seen, 1'b1);
        check_b("idle_busy", BUSY, 1'b0);
        check_b("idle_out_valid", OUT_VALID, 1'b0);
        check_w("payload_taken", 32'(pidx), 32'(pay.size()));
        check_w("frame_size", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_w($sformatf("frame_byte[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (chk_span)
            check_w("frame_cycles", 32'(cyc - first), 32'(2 + len + c_csum_bytes));
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
    endtask

    initial begin
        byte_q_t pay;
        int      len;

        // Reset values
        #1 RST_X = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_w("rst_out", 32'(OUT), 32'h0);
        check_b("rst_out_valid", OUT_VALID, 1'b0);
        check_b("rst_in_ready", IN_READY, 1'b0);
        check_b("rst_busy", BUSY, 1'b0);
        check_b("rst_done", DONE, 1'b0);
        check_b("rst_err", ERR, 1'b0);
        @(negedge CLK) RST_X = 1'b1;
        @(posedge CLK); #1;

        // Basic frame at full throughput
        pay = {8'h01, 8'h02, 8'h03};
        run_frame(3, pay, 100, 100, 1'b0, 1'b1);

        // Zero length
        pay = {};
        run_frame(0, pay, 100, 100, 1'b0, 1'b1);

        // Over-length request
        START = 1'b1;
        LEN   = 8'd17;
        @(posedge CLK); #1;
        START = 1'b0;
        check_b("ovl_err", ERR, 1'b1);
        check_b("ovl_busy", BUSY, 1'b0);
        check_b("ovl_out_valid", OUT_VALID, 1'b0);
        @(posedge CLK); #1;
        check_b("ovl_err_one_cycle", ERR, 1'b0);
        check_b("ovl_busy_after", BUSY, 1'b0);

        // Backpressure on a short frame
        pay = {8'hAA, 8'h55};
        run_frame(2, pay, 35, 100, 1'b0, 1'b0);

        // START while busy, and the MAX_LEN boundary at full rate
        pay = {};
        for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
        run_frame(8, pay, 100, 100, 1'b1, 1'b1);
        pay = {};
        for (int i = 0; i < c_max_len; i++) pay.push_back(8'($urandom));
        run_frame(c_max_len, pay, 100, 100, 1'b0, 1'b1);

        // Randomized frames with random stalls on both sides
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(c_max_len);
            pay = {};
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            run_frame(len, pay, $urandom_range(100, 30), $urandom_range(100, 30),
                      (len >= 5), 1'b0);
        end

        // Reset mid-frame, then a fresh frame
        START = 1'b1;
        LEN   = 8'd5;
        @(posedge CLK); #1;
        START     = 1'b0;
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        IN        = 8'h11;
        repeat (3) @(posedge CLK);
        #2 RST_X = 1'b0;
        #1;
        check_w("midrst_out", 32'(OUT), 32'h0);
        check_b("midrst_out_valid", OUT_VALID, 1'b0);
        check_b("midrst_in_ready", IN_READY, 1'b0);
        check_b("midrst_busy", BUSY, 1'b0);
        check_b("midrst_done", DONE, 1'b0);
        @(negedge CLK);
        RST_X    = 1'b1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        check_b("midrst_no_done", DONE, 1'b0);
        check_b("midrst_stays_idle", BUSY, 1'b0);
        pay = {8'h7E};
        run_frame(1, pay, 100, 100, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
